// File: rtl/countone_mul_arbiter.sv
// rtl/countone_mul_arbiter.sv - round-robin arbiter sharing one pipelined 16x16 multiplier
// Tags each issued operand pair with its owner and stalls the multiplier while a result waits.
module countone_mul_arbiter #(
  parameter int N_REQ   = 2,
  parameter int LATENCY = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_p,
  output logic                  mul_ce,
  output logic [15:0]           mul_din0,
  output logic [15:0]           mul_din1,
  input  logic [31:0]           mul_dout
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]     last_issued;
  logic [LATENCY-1:0] tag_valid;
  logic [IDW-1:0]     tag_id [LATENCY];
  logic               tail_valid;
  logic [IDW-1:0]     tail_id;
  logic               tail_ready;
  logic               grant_any;
  logic [IDW-1:0]     grant_id;
  logic               issue;

  assign tail_valid = tag_valid[LATENCY-1];
  assign tail_id    = tag_id[LATENCY-1];
  assign grant_any  = |req_valid;
  assign mul_ce     = !(tail_valid && !tail_ready);
  assign issue      = mul_ce && grant_any;
  assign rsp_p      = mul_dout;

  // Round-robin: the valid requester closest after last_issued (cyclically) wins.
  always_comb begin
    int d;
    int best;
    best     = N_REQ;
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - 1 - int'(last_issued)) % N_REQ;
      if (req_valid[i] && d < best) begin
        best     = d;
        grant_id = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    tail_ready = 1'b0;
    mul_din0   = '0;
    mul_din1   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && grant_id == IDW'(i)) begin
        req_ready[i] = mul_ce;
        mul_din0     = req_a[16*i +: 16];
        mul_din1     = req_b[16*i +: 16];
      end
      if (tail_id == IDW'(i)) begin
        rsp_valid[i] = tail_valid;
        tail_ready   = rsp_ready[i];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tag_valid   <= '0;
      last_issued <= IDW'(N_REQ - 1);
    end else if (mul_ce) begin
      for (int i = 1; i < LATENCY; i++) tag_valid[i] <= tag_valid[i-1];
      tag_valid[0] <= issue;
      if (issue) last_issued <= grant_id;
    end
  end

  // Owner ids are only meaningful alongside tag_valid, so they need no reset.
  always_ff @(posedge ap_clk) begin
    if (mul_ce) begin
      for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
      tag_id[0] <= grant_id;
    end
  end

endmodule
